// File: rtl/mfm_pkg.sv
// Shared types and constants for the MFM track sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mfm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_PRIME,
      ST_STREAM,
      ST_GAP
   } state_t;

   localparam int         MFM_CELLS_PER_BYTE = 16;
   localparam int         MARK_CLK_BIT       = 2;
   localparam logic [7:0] GAP_BYTE_DEFAULT   = 8'h4E;

endpackage

// File: rtl/mfm_encoder.sv
// MFM-encodes one byte into 16 cells, (clock, data) pairs for bits 7..0, MSB first.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to sample the word.
//
// Ports:
//   data      byte to encode
//   mark      1 = suppress the clock cell of data bit MARK_CLK_BIT (address mark)
//   prev_data last data cell of the preceding byte
//   cells     encoded word, cells[15] goes out first
//   new_prev  last data cell of this byte, carried into the next byte
module mfm_encoder
   import mfm_pkg::*;
(
   input  logic [7:0]                    data,
   input  logic                          mark,
   input  logic                          prev_data,
   output logic [MFM_CELLS_PER_BYTE-1:0] cells,
   output logic                          new_prev
);

   always_comb begin
      logic p;
      cells = '0;
      p     = prev_data;
      for (int i = 7; i >= 0; i--) begin
         // A clock cell is written only between two zero data cells.
         cells[2*i+1] = ~p & ~data[i] & ~(mark && (i == MARK_CLK_BIT));
         cells[2*i]   = data[i];
         p            = data[i];
      end
      new_prev = data[0];
   end

endmodule

// File: rtl/mfm_track_sequencer.sv
// Streams one track of MFM cells from a track RAM, restarting on each index pulse.
// Latency: index_l fall -> PRIME 3 cycles later -> first cell + track_sync one cycle after PRIME.
// Backpressure: none; the output stage takes one cell every clk5, RAM reads are fixed-schedule.
//
// Ports:
//   clk5, reset         cell clock, synchronous active-high reset
//   arm                 level enable; 0 forces IDLE and clears wrapped
//   index_l             asynchronous active-low index pulse
//   mem_addr/rd_en      track RAM read request, data returns on mem_rdata next cycle
//   mem_rdata           [7:0] byte, [8] mark flag
//   mfm_out             serial cell stream
//   track_sync          1-cycle pulse on the first cell of byte 0
//   busy                1 while PRIME, STREAM or GAP
//   wrapped             sticky: index arrived before the track image was fully sent
module mfm_track_sequencer
   import mfm_pkg::*;
#(
   parameter int         TRACK_BYTES = 5208,
   parameter int         ADDR_W      = 13,
   parameter logic [7:0] GAP_BYTE    = GAP_BYTE_DEFAULT
)
(
   input  logic              clk5,
   input  logic              reset,
   input  logic              arm,
   input  logic              index_l,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [8:0]        mem_rdata,
   output logic              mfm_out,
   output logic              track_sync,
   output logic              busy,
   output logic              wrapped
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TRACK_BYTES - 1);

   // Index synchronizer; s3 keeps the previous s2 so one low pulse yields one edge.
   logic s1, s2, s3;
   logic idx_edge;

   always_ff @(posedge clk5) begin
      if (reset) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= index_l;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign idx_edge = s3 & ~s2;

   state_t                          state, state_nxt;
   logic [3:0]                      cnt;
   logic                            first;
   logic [MFM_CELLS_PER_BYTE-1:0]   word_q;
   logic                            prev_data;
   logic [ADDR_W-1:0]               byte_idx;
   logic                            wrapped_q;

   logic                            last_cell;
   logic                            last_byte;
   logic                            enc_gap;
   logic [7:0]                      enc_data;
   logic                            enc_mark;
   logic [MFM_CELLS_PER_BYTE-1:0]   enc_cells;
   logic                            enc_prev;
   logic [MFM_CELLS_PER_BYTE-1:0]   cur_word;

   assign last_cell = (cnt == 4'd15);
   assign last_byte = (byte_idx == LAST_ADDR);

   // Gap filler takes over after the last image byte; it never carries a mark.
   assign enc_gap  = (state == ST_GAP) || (last_cell && last_byte);
   assign enc_data = enc_gap ? GAP_BYTE : mem_rdata[7:0];
   assign enc_mark = ~enc_gap & mem_rdata[8];

   mfm_encoder u_enc (
      .data      (enc_data),
      .mark      (enc_mark),
      .prev_data (prev_data),
      .cells     (enc_cells),
      .new_prev  (enc_prev)
   );

   // Byte 0 arrives in the same cycle as its first cell, so it bypasses the register.
   assign cur_word = first ? enc_cells : word_q;

   always_ff @(posedge clk5) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      mem_rd_en  = 1'b0;
      mem_addr   = byte_idx;
      track_sync = 1'b0;
      mfm_out    = 1'b0;
      case (state)
         ST_IDLE: begin
            state_nxt = ST_ARMED;
         end
         ST_ARMED: begin
            if (idx_edge) state_nxt = ST_PRIME;
         end
         ST_PRIME: begin
            busy      = 1'b1;
            mem_rd_en = 1'b1;
            mem_addr  = '0;
            state_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            busy       = 1'b1;
            track_sync = first;
            mfm_out    = cur_word[4'd15 - cnt];
            // Prefetch lands on cell 15 and is registered on the 15->0 boundary.
            if (cnt == 4'd14 && !last_byte) begin
               mem_rd_en = 1'b1;
               mem_addr  = byte_idx + ADDR_W'(1);
            end
            if (idx_edge)                     state_nxt = ST_PRIME;
            else if (last_cell && last_byte)  state_nxt = ST_GAP;
         end
         ST_GAP: begin
            busy    = 1'b1;
            mfm_out = cur_word[4'd15 - cnt];
            if (idx_edge) state_nxt = ST_PRIME;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      if (!arm) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk5) begin
      if (reset) begin
         cnt       <= '0;
         first     <= 1'b0;
         word_q    <= '0;
         prev_data <= 1'b0;
         byte_idx  <= '0;
         wrapped_q <= 1'b0;
      end else begin
         if (!arm)                                 wrapped_q <= 1'b0;
         else if (state == ST_STREAM && idx_edge)  wrapped_q <= 1'b1;

         if (state == ST_PRIME) begin
            cnt       <= '0;
            first     <= 1'b1;
            prev_data <= 1'b0;
            byte_idx  <= '0;
         end else if (state == ST_STREAM || state == ST_GAP) begin
            cnt   <= cnt + 4'd1;
            first <= 1'b0;
            if (first || last_cell) begin
               word_q    <= enc_cells;
               prev_data <= enc_prev;
            end
            if (state == ST_STREAM && last_cell && !last_byte)
               byte_idx <= byte_idx + ADDR_W'(1);
         end
      end
   end

   assign wrapped = wrapped_q;

endmodule

// File: tb/tb_mfm_track_sequencer.sv
module tb_mfm_track_sequencer;

   localparam int TB = 4;

   logic        clk5;
   logic        reset;
   logic        arm;
   logic        index_l;
   logic [12:0] mem_addr;
   logic        mem_rd_en;
   logic [8:0]  mem_rdata;
   logic        mfm_out;
   logic        track_sync;
   logic        busy;
   logic        wrapped;

   logic [8:0]  ram [0:TB-1];

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   mfm_track_sequencer #(.TRACK_BYTES(TB), .ADDR_W(13), .GAP_BYTE(8'h4E)) dut (
      .clk5       (clk5),
      .reset      (reset),
      .arm        (arm),
      .index_l    (index_l),
      .mem_addr   (mem_addr),
      .mem_rd_en  (mem_rd_en),
      .mem_rdata  (mem_rdata),
      .mfm_out    (mfm_out),
      .track_sync (track_sync),
      .busy       (busy),
      .wrapped    (wrapped)
   );

   initial begin
      clk5 = 1'b0;
      forever #5 clk5 = ~clk5;
   end

   // Track RAM: data only valid the cycle after a read, garbage otherwise.
   always @(posedge clk5) begin
      if (mem_rd_en) mem_rdata <= (int'(mem_addr) < TB) ? ram[mem_addr] : 9'h1FF;
      else           mem_rdata <= 9'($urandom);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [8:0] byte_at(input int b);
      if (b < TB) return ram[b];
      return {1'b0, 8'h4E};
   endfunction

   // Cell p of the track stream counted from the first cell of byte 0.
   function automatic logic exp_cell(input int p);
      int b, c, i;
      logic [8:0] bv, pv;
      logic d, pr;
      b  = p / 16;
      c  = p % 16;
      i  = 7 - c / 2;
      bv = byte_at(b);
      d  = bv[i];
      if (c % 2 == 1) return d;
      if (i == 7) begin
         if (b == 0) pr = 1'b0;
         else begin
            pv = byte_at(b - 1);
            pr = pv[0];
         end
      end else begin
         pr = bv[i+1];
      end
      return ~pr & ~d & ~(bv[8] && i == 2);
   endfunction

   function automatic logic [15:0] model_word(input int b);
      logic [15:0] w;
      for (int k = 0; k < 16; k++) w[15-k] = exp_cell(16*b + k);
      return w;
   endfunction

   int m_ph  = 0;   // 0 idle, 1 armed, 2 prime, 3 running from pos
   int m_pos = 0;
   bit m_wr  = 0;
   bit h1 = 1, h2 = 1, h3 = 1;
   bit m_e;

   initial begin
      forever begin
         @(posedge clk5);
         m_e = h3 & ~h2;
         if (reset) begin
            m_ph = 0; m_pos = 0; m_wr = 0;
            h1 = 1; h2 = 1; h3 = 1;
         end else begin
            h3 = h2; h2 = h1; h1 = index_l;
            if (!arm) begin
               m_ph = 0;
               m_wr = 0;
            end else begin
               case (m_ph)
                  0: m_ph = 1;
                  1: if (m_e) m_ph = 2;
                  2: begin m_ph = 3; m_pos = 0; end
                  default: begin
                     if (m_e) begin
                        if (m_pos < 16*TB) m_wr = 1;
                        m_ph = 2;
                     end else begin
                        m_pos++;
                     end
                  end
               endcase
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk5);
         if (chk_en) begin
            logic e_rd;
            e_rd = (m_ph == 2) || (m_ph == 3 && (m_pos % 16) == 14 && (m_pos / 16) < TB - 1);
            chk("busy", busy, (m_ph == 2 || m_ph == 3));
            chk("track_sync", track_sync, (m_ph == 3 && m_pos == 0));
            chk("mfm_out", mfm_out, (m_ph == 3) ? exp_cell(m_pos) : 1'b0);
            chk("wrapped", wrapped, m_wr);
            chk("mem_rd_en", mem_rd_en, e_rd);
            if (e_rd) chk("mem_addr", mem_addr, (m_ph == 2) ? 0 : m_pos / 16 + 1);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk5);
      #2;
   endtask

   task automatic pulse(input int len);
      index_l = 1'b0;
      repeat (len) step();
      index_l = 1'b1;
   endtask

   task automatic wait_sync(input string nm);
      bit ok;
      ok = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk5);
         if (track_sync) begin
            ok = 1;
            break;
         end
      end
      chk(nm, ok, 1'b1);
   endtask

   // Samples the current cell and the following 15.
   task automatic grab16(output logic [15:0] w);
      w[15] = mfm_out;
      for (int j = 14; j >= 0; j--) begin
         @(negedge clk5);
         w[j] = mfm_out;
      end
   endtask

   task automatic rearm();
      arm = 1'b0;
      step();
      step();
   endtask

   logic [15:0] w;
   int          nsync;
   int          plen;

   initial begin
      reset = 1'b1; arm = 1'b0; index_l = 1'b1;
      for (int k = 0; k < TB; k++) ram[k] = 9'h000;
      step();
      chk_en = 1;
      step();
      @(negedge clk5);
      chk("rst_busy", busy, 1'b0);
      chk("rst_mfm_out", mfm_out, 1'b0);
      chk("rst_sync", track_sync, 1'b0);
      chk("rst_rd_en", mem_rd_en, 1'b0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wrapped", wrapped, 1'b0);
      reset = 1'b0; arm = 1'b1;
      step(); step();

      // All-zero image: first byte and first gap byte.
      pulse(2);
      wait_sync("zero_sync");
      grab16(w);
      chk("zero_byte0", w, 16'hAAAA);
      chk("model_zero_byte0", model_word(0), 16'hAAAA);
      repeat (49) @(negedge clk5);
      grab16(w);
      chk("gap_byte", w, 16'h9254);
      chk("model_gap_byte", model_word(TB), 16'h9254);
      pulse(2);
      wait_sync("gap_restart_sync");
      chk("gap_restart_wrapped", wrapped, 1'b0);

      // Address mark A1 with and without the missing clock.
      rearm();
      ram[0] = 9'h1A1;
      arm = 1'b1; step(); step();
      pulse(2);
      wait_sync("mark_sync");
      grab16(w);
      chk("mark_a1", w, 16'h4489);
      chk("model_mark_a1", model_word(0), 16'h4489);
      rearm();
      ram[0] = 9'h0A1;
      arm = 1'b1; step(); step();
      pulse(2);
      wait_sync("nomark_sync");
      grab16(w);
      chk("nomark_a1", w, 16'h44A9);

      // Index edge during cell 7 of byte 2.
      rearm();
      for (int k = 0; k < TB; k++) ram[k] = {1'b0, 8'($urandom)};
      arm = 1'b1; step(); step();
      pulse(2);
      wait_sync("mid_first_sync");
      repeat (37) @(negedge clk5);
      index_l = 1'b0;
      repeat (2) @(negedge clk5);
      index_l = 1'b1;
      wait_sync("mid_restart_sync");
      chk("mid_wrapped", wrapped, 1'b1);

      // arm dropped mid-byte, then an index while disarmed.
      repeat (5) @(negedge clk5);
      arm = 1'b0;
      @(negedge clk5);
      chk("disarm_busy", busy, 1'b0);
      chk("disarm_mfm_out", mfm_out, 1'b0);
      chk("disarm_wrapped", wrapped, 1'b0);
      index_l = 1'b0;
      nsync = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk5);
         if (k == 2) index_l = 1'b1;
         if (track_sync) nsync++;
      end
      chk("disarm_no_sync", nsync, 0);

      // Long index pulse gives a single restart.
      arm = 1'b1; step(); step();
      index_l = 1'b0;
      nsync = 0;
      for (int k = 0; k < 130; k++) begin
         @(negedge clk5);
         if (k == 100) index_l = 1'b1;
         if (track_sync) nsync++;
      end
      chk("long_pulse_syncs", nsync, 1);

      // Reset while streaming.
      pulse(2);
      wait_sync("pre_reset_sync");
      repeat (10) @(negedge clk5);
      reset = 1'b1;
      @(negedge clk5);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_mfm_out", mfm_out, 1'b0);
      chk("midrst_rd_en", mem_rd_en, 1'b0);
      chk("midrst_sync", track_sync, 1'b0);
      reset = 1'b0;
      step();

      // Randomized rounds: random image, index pulses, occasional disarm/reset.
      for (int r = 0; r < 20; r++) begin
         rearm();
         for (int k = 0; k < TB; k++)
            ram[k] = {($urandom_range(0, 3) == 0), 8'($urandom)};
         arm = 1'b1;
         plen = 0;
         for (int c = 0; c < 160; c++) begin
            int rv;
            step();
            rv = $urandom_range(0, 199);
            if (plen > 0) begin
               plen--;
               if (plen == 0) index_l = 1'b1;
            end else if (rv < 5) begin
               index_l = 1'b0;
               plen = $urandom_range(1, 4);
            end
            if (rv == 100) arm = ~arm;
            reset = (rv == 101);
         end
         reset = 1'b0;
         index_l = 1'b1;
      end

      step(); step();
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
